// File: rtl/gen_sample_fifo.sv
// Single-clock sample FIFO between the function generator and its consumer.
// Registered read port (1-cycle latency), next-state flags, sticky error bits.
module gen_sample_fifo #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 4,
   parameter int AFULL_LEVEL  = 12,
   parameter int AEMPTY_LEVEL = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  rd_en_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  rd_valid_o,
   output logic                  full_o,
   output logic                  empty_o,
   output logic                  almost_full_o,
   output logic                  almost_empty_o,
   output logic [ADDR_WIDTH:0]   count_o,
   output logic                  overflow_o,
   output logic                  underflow_o
);

   localparam int                DEPTH    = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] C_DEPTH  = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] C_AFULL  = (ADDR_WIDTH + 1)'(AFULL_LEVEL);
   localparam logic [ADDR_WIDTH:0] C_AEMPTY = (ADDR_WIDTH + 1)'(AEMPTY_LEVEL);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [ADDR_WIDTH:0]   r_count;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_rd_valid;
   logic                  r_full;
   logic                  r_empty;
   logic                  r_afull;
   logic                  r_aempty;
   logic                  r_overflow;
   logic                  r_underflow;

   logic                  w_rd_acc;
   logic                  w_wr_acc;
   logic [ADDR_WIDTH:0]   w_count_nxt;

   // A full FIFO still takes a write when the same edge frees a slot.
   assign w_rd_acc = rd_en_i & ~r_empty;
   assign w_wr_acc = wr_en_i & (~r_full | w_rd_acc);

   always_comb begin
      // NOTE: default assignment first, so no path leaves w_count_nxt unassigned (no latch).
      w_count_nxt = r_count;
      if (w_wr_acc && !w_rd_acc)
         w_count_nxt = r_count + 1'b1;
      else if (w_rd_acc && !w_wr_acc)
         w_count_nxt = r_count - 1'b1;
   end

   // NOTE: storage array has no reset; the pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (rst && w_wr_acc)
         r_mem[r_wr_ptr] <= data_i;
   end

   // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_data      <= '0;
         r_rd_valid  <= 1'b0;
         r_full      <= 1'b0;
         r_empty     <= 1'b1;
         r_afull     <= 1'b0;
         r_aempty    <= 1'b1;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_wr_acc)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd_acc) begin
            r_data   <= r_mem[r_rd_ptr];
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         r_rd_valid  <= w_rd_acc;
         r_count     <= w_count_nxt;
         // Flags come from the next count so they line up with count_o.
         r_full      <= (w_count_nxt == C_DEPTH);
         r_empty     <= (w_count_nxt == '0);
         r_afull     <= (w_count_nxt >= C_AFULL);
         r_aempty    <= (w_count_nxt <= C_AEMPTY);
         r_overflow  <= r_overflow  | (wr_en_i & ~w_wr_acc);
         r_underflow <= r_underflow | (rd_en_i & r_empty);
      end
   end

   assign data_o         = r_data;
   assign rd_valid_o     = r_rd_valid;
   assign full_o         = r_full;
   assign empty_o        = r_empty;
   assign almost_full_o  = r_afull;
   assign almost_empty_o = r_aempty;
   assign count_o        = r_count;
   assign overflow_o     = r_overflow;
   assign underflow_o    = r_underflow;

endmodule

// File: tb/tb_gen_sample_fifo.sv
// Scoreboard bench for gen_sample_fifo: stimulus pushes expected read data,
// a negedge monitor pops and compares on every rd_valid_o pulse.
module tb_gen_sample_fifo;

   localparam int DW    = 32;
   localparam int AW    = 4;
   localparam int DEPTH = 16;

   logic          clk     = 1'b0;
   logic          rst     = 1'b0;
   logic          wr_en_i = 1'b0;
   logic          rd_en_i = 1'b0;
   logic [DW-1:0] data_i  = '0;
   logic [DW-1:0] data_o;
   logic          rd_valid_o, full_o, empty_o, almost_full_o, almost_empty_o;
   logic [AW:0]   count_o;
   logic          overflow_o, underflow_o;

   int n_checks = 0;
   int n_fail   = 0;
   int n_pushed = 0;
   int n_popped = 0;

   logic [DW-1:0] model_q [$];
   logic [DW-1:0] exp_q   [$];

   gen_sample_fifo dut (
      .clk           (clk),
      .rst           (rst),
      .wr_en_i       (wr_en_i),
      .data_i        (data_i),
      .rd_en_i       (rd_en_i),
      .data_o        (data_o),
      .rd_valid_o    (rd_valid_o),
      .full_o        (full_o),
      .empty_o       (empty_o),
      .almost_full_o (almost_full_o),
      .almost_empty_o(almost_empty_o),
      .count_o       (count_o),
      .overflow_o    (overflow_o),
      .underflow_o   (underflow_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // One clock of stimulus; the reference queue decides which reads are accepted.
   task automatic cyc(input logic wr, input logic [DW-1:0] din, input logic rd);
      bit racc;
      bit wacc;
      @(negedge clk);
      wr_en_i = wr;
      data_i  = din;
      rd_en_i = rd;
      racc = rd && (model_q.size() != 0);
      wacc = wr && ((model_q.size() < DEPTH) || racc);
      if (racc) begin
         exp_q.push_back(model_q.pop_front());
         n_pushed++;
      end
      if (wacc)
         model_q.push_back(din);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic wr, input logic [DW-1:0] din);
      @(negedge clk);
      rst     = 1'b0;
      wr_en_i = wr;
      data_i  = din;
      rd_en_i = 1'b0;
      model_q.delete();
      @(posedge clk);
      #1;
      rst     = 1'b1;
      wr_en_i = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_data"},    64'(data_o),         64'h0);
      check({tag, "_valid"},   64'(rd_valid_o),     64'h0);
      check({tag, "_full"},    64'(full_o),         64'h0);
      check({tag, "_empty"},   64'(empty_o),        64'h1);
      check({tag, "_afull"},   64'(almost_full_o),  64'h0);
      check({tag, "_aempty"},  64'(almost_empty_o), 64'h1);
      check({tag, "_count"},   64'(count_o),        64'h0);
      check({tag, "_ovf"},     64'(overflow_o),     64'h0);
      check({tag, "_unf"},     64'(underflow_o),    64'h0);
   endtask

   // Monitor: every read pulse must match the oldest outstanding expectation.
   initial begin
      forever begin
         @(negedge clk);
         if (rd_valid_o) begin
            n_popped++;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL sb_unexpected: got read data 0x%0h, expected no read", data_o);
            end else begin
               check("sb_data", 64'(data_o), 64'(exp_q.pop_front()));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test by 200000 ns, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [DW-1:0] t1_vec [5];
      t1_vec = '{32'h1000_0000, 32'h0C00_0000, 32'hF400_0000, 32'h0000_0001, 32'h7FFF_FFFF};

      do_reset(1'b0, '0);
      check_reset_state("rst0");

      // 1: five writes then five reads, bit-exact and in order
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, t1_vec[i], 1'b0);
         if (i == 1) check("t1_aempty_at2", 64'(almost_empty_o), 64'h1);
         if (i == 2) check("t1_aempty_at3", 64'(almost_empty_o), 64'h0);
      end
      check("t1_count5", 64'(count_o), 64'd5);
      check("t1_empty0", 64'(empty_o), 64'h0);
      for (int i = 0; i < 5; i++) begin
         cyc(1'b0, '0, 1'b1);
         check("t1_valid", 64'(rd_valid_o), 64'h1);
         check("t1_data",  64'(data_o),     64'(t1_vec[i]));
      end
      check("t1_count0", 64'(count_o), 64'd0);
      check("t1_empty1", 64'(empty_o), 64'h1);
      cyc(1'b0, '0, 1'b0);
      check("t1_valid_idle", 64'(rd_valid_o), 64'h0);
      check("t1_ovf", 64'(overflow_o), 64'h0);
      check("t1_unf", 64'(underflow_o), 64'h0);

      // 2: fill to full, overflow write dropped, drain 0..15
      for (int i = 0; i < 16; i++) begin
         cyc(1'b1, DW'(i), 1'b0);
         if (i == 10) check("t2_afull_at11", 64'(almost_full_o), 64'h0);
         if (i == 11) check("t2_afull_at12", 64'(almost_full_o), 64'h1);
         if (i == 14) check("t2_full_at15",  64'(full_o),        64'h0);
      end
      check("t2_full",    64'(full_o),  64'h1);
      check("t2_count16", 64'(count_o), 64'd16);
      cyc(1'b1, 32'hDEAD_BEEF, 1'b0);
      check("t2_count_ovf", 64'(count_o),    64'd16);
      check("t2_ovf",       64'(overflow_o), 64'h1);
      for (int i = 0; i < 16; i++) begin
         cyc(1'b0, '0, 1'b1);
         check("t2_drain", 64'(data_o), 64'(i));
      end
      check("t2_empty", 64'(empty_o), 64'h1);

      // 3: at full, 20 cycles of simultaneous write+read
      do_reset(1'b0, '0);
      for (int i = 0; i < 16; i++) cyc(1'b1, DW'(100 + i), 1'b0);
      for (int i = 0; i < 20; i++) begin
         cyc(1'b1, DW'(200 + i), 1'b1);
         check("t3_count", 64'(count_o),    64'd16);
         check("t3_full",  64'(full_o),     64'h1);
         check("t3_ovf",   64'(overflow_o), 64'h0);
         check("t3_valid", 64'(rd_valid_o), 64'h1);
         check("t3_data",  64'(data_o),     (i < 16) ? 64'(100 + i) : 64'(200 + i - 16));
      end
      for (int i = 0; i < 16; i++) cyc(1'b0, '0, 1'b1);
      check("t3_drained", 64'(empty_o), 64'h1);

      // 4: underflow from empty, then write+read on empty
      cyc(1'b0, '0, 1'b1);
      check("t4_unf",   64'(underflow_o), 64'h1);
      check("t4_valid", 64'(rd_valid_o),  64'h0);
      check("t4_hold",  64'(data_o),      64'd219);
      check("t4_count", 64'(count_o),     64'd0);
      cyc(1'b1, 32'h0000_ABCD, 1'b1);
      check("t4_wr_rd_count", 64'(count_o),    64'd1);
      check("t4_wr_rd_valid", 64'(rd_valid_o), 64'h0);
      check("t4_wr_rd_empty", 64'(empty_o),    64'h0);
      cyc(1'b0, '0, 1'b1);
      check("t4_rd_valid", 64'(rd_valid_o), 64'h1);
      check("t4_rd_data",  64'(data_o),     64'h0000_ABCD);

      // 5: wrap-around at steady occupancy 3
      for (int i = 0; i < 3; i++) cyc(1'b1, DW'(32'hA1 + i), 1'b0);
      for (int i = 0; i < 40; i++) begin
         cyc(1'b1, 32'h5000_0000 + DW'(i), 1'b1);
         check("t5_count", 64'(count_o), 64'd3);
         check("t5_data",  64'(data_o),
               (i < 3) ? 64'(32'hA1 + i) : 64'(32'h5000_0000 + i - 3));
      end
      for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1);
      check("t5_empty", 64'(empty_o), 64'h1);

      // 6: reset with a write pending is ignored
      for (int i = 0; i < 7; i++) cyc(1'b1, 32'h7700_0000 + DW'(i), 1'b0);
      check("t6_count7", 64'(count_o), 64'd7);
      do_reset(1'b1, 32'h0000_0BAD);
      check_reset_state("rst6");
      cyc(1'b1, 32'h0000_600D, 1'b0);
      check("t6_count1", 64'(count_o), 64'd1);
      cyc(1'b0, '0, 1'b1);
      check("t6_valid", 64'(rd_valid_o), 64'h1);
      check("t6_data",  64'(data_o),     64'h0000_600D);
      check("t6_empty", 64'(empty_o),    64'h1);

      cyc(1'b0, '0, 1'b0);
      cyc(1'b0, '0, 1'b0);
      check("sb_drained", 64'(exp_q.size()), 64'd0);
      check("rd_pulses",  64'(n_popped),     64'(n_pushed));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
